// File: rtl/ctrl_layer_seq_if.sv
// Bundle of host, datapath and volume-counter signals for the layer sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface ctrl_layer_seq_if #(
    parameter int unsigned VW = 16
);
    logic          layer_start;
    logic [VW-1:0] num_vol;
    logic          abort;
    logic          layer_busy;
    logic          layer_done;
    logic          layer_err;
    logic          vol_start;
    logic          vol_done;
    logic [VW-1:0] vol_idx;
    logic          cnt_load;
    logic          cnt_in_vol;
    logic          cnt_clear_vol;
    logic [VW-1:0] cnt_max_val;
    logic          cnt_op_done;

    modport master (
        input  layer_start, num_vol, abort, vol_done, cnt_op_done,
        output layer_busy, layer_done, layer_err, vol_start, vol_idx,
               cnt_load, cnt_in_vol, cnt_clear_vol, cnt_max_val
    );

    modport slave (
        output layer_start, num_vol, abort, vol_done, cnt_op_done,
        input  layer_busy, layer_done, layer_err, vol_start, vol_idx,
               cnt_load, cnt_in_vol, cnt_clear_vol, cnt_max_val
    );
endinterface

// File: rtl/ctrl_layer_seq.sv
// Layer-sequencing controller: walks the volumes of one conv layer, drives the
// volume counter and cross-checks its op_done flag against a shadow index.
module ctrl_layer_seq #(
    parameter int unsigned MNV = 224*224
) (
    input  logic              clk,
    input  logic              rst_n,
    ctrl_layer_seq_if.master  bus
);
    localparam int unsigned VW = $clog2(MNV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_CHECK,
        S_ADV,
        S_FINISH
    } state_e;

    state_e        state_q, state_d;
    logic [VW-1:0] cnt_max_val_q, cnt_max_val_d;
    logic [VW-1:0] vol_idx_q, vol_idx_d;
    logic          layer_err_q, layer_err_d;
    logic          layer_busy_q, layer_busy_d;
    logic          layer_done_q, layer_done_d;
    logic          vol_start_q, vol_start_d;
    logic          cnt_load_q, cnt_load_d;
    logic          cnt_in_vol_q, cnt_in_vol_d;
    logic          cnt_clear_vol_q, cnt_clear_vol_d;

    logic          abort_act;
    logic          last_vol;

    assign abort_act = bus.abort && (state_q != S_IDLE) && (state_q != S_FINISH);
    assign last_vol  = (vol_idx_q == (cnt_max_val_q - VW'(1)));

    // Next-state, shadow count and error flag; strobes decode the next state so
    // each registered strobe is high exactly while the FSM sits in its state.
    always_comb begin
        state_d       = state_q;
        cnt_max_val_d = cnt_max_val_q;
        vol_idx_d     = vol_idx_q;
        layer_err_d   = layer_err_q;
        cnt_in_vol_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.layer_start) begin
                    if (bus.num_vol != '0) begin
                        cnt_max_val_d = bus.num_vol;
                        vol_idx_d     = '0;
                        layer_err_d   = 1'b0;
                        state_d       = S_LOAD;
                    end else begin
                        layer_err_d = 1'b1;
                        state_d     = S_FINISH;
                    end
                end
            end
            S_LOAD:   state_d = S_SETTLE;
            S_SETTLE: state_d = S_START;
            S_START:  state_d = S_WAIT;
            S_WAIT: begin
                if (bus.vol_done) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (bus.cnt_op_done && last_vol) begin
                    state_d = S_FINISH;
                end else if (!bus.cnt_op_done && !last_vol) begin
                    cnt_in_vol_d = 1'b1;
                    vol_idx_d    = vol_idx_q + VW'(1);
                    state_d      = S_ADV;
                end else begin
                    // counter and shadow index disagree about the last volume
                    layer_err_d = 1'b1;
                    state_d     = S_FINISH;
                end
            end
            S_ADV:    state_d = S_START;
            S_FINISH: begin
                vol_idx_d = '0;
                state_d   = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase

        if (abort_act) begin
            state_d      = S_FINISH;
            layer_err_d  = 1'b1;
            cnt_in_vol_d = 1'b0;
            vol_idx_d    = vol_idx_q;
        end

        layer_busy_d    = (state_d != S_IDLE);
        vol_start_d     = (state_d == S_START);
        cnt_load_d      = (state_d == S_LOAD);
        layer_done_d    = (state_d == S_FINISH);
        cnt_clear_vol_d = (state_d == S_FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            cnt_max_val_q   <= '0;
            vol_idx_q       <= '0;
            layer_err_q     <= 1'b0;
            layer_busy_q    <= 1'b0;
            layer_done_q    <= 1'b0;
            vol_start_q     <= 1'b0;
            cnt_load_q      <= 1'b0;
            cnt_in_vol_q    <= 1'b0;
            cnt_clear_vol_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_max_val_q   <= cnt_max_val_d;
            vol_idx_q       <= vol_idx_d;
            layer_err_q     <= layer_err_d;
            layer_busy_q    <= layer_busy_d;
            layer_done_q    <= layer_done_d;
            vol_start_q     <= vol_start_d;
            cnt_load_q      <= cnt_load_d;
            cnt_in_vol_q    <= cnt_in_vol_d;
            cnt_clear_vol_q <= cnt_clear_vol_d;
        end
    end

    assign bus.layer_busy    = layer_busy_q;
    assign bus.layer_done    = layer_done_q;
    assign bus.layer_err     = layer_err_q;
    assign bus.vol_start     = vol_start_q;
    assign bus.vol_idx       = vol_idx_q;
    assign bus.cnt_load      = cnt_load_q;
    assign bus.cnt_in_vol    = cnt_in_vol_q;
    assign bus.cnt_clear_vol = cnt_clear_vol_q;
    assign bus.cnt_max_val   = cnt_max_val_q;
endmodule

// File: tb/tb_ctrl_layer_seq.sv
// Scoreboard bench for ctrl_layer_seq with an attached volume-counter model.
// The driver pushes the expected event list per layer; a monitor pops and compares.
module tb_ctrl_layer_seq;
    localparam int unsigned MNV = 224*224;
    localparam int unsigned VW  = $clog2(MNV);

    localparam int M_NORM   = 0;
    localparam int M_ABORT  = 1;
    localparam int M_DESYNC = 2;
    localparam int M_EARLY  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ctrl_layer_seq_if #(.VW(VW)) bus ();
    ctrl_layer_seq #(.MNV(MNV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Volume counter model: loaded to volume 0, op_done registered one edge later.
    logic [VW-1:0] cm_cnt;
    logic          cm_od;
    logic          force_od;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cm_cnt <= '0;
            cm_od  <= 1'b0;
        end else begin
            if (bus.cnt_load || bus.cnt_clear_vol) cm_cnt <= '0;
            else if (bus.cnt_in_vol)               cm_cnt <= cm_cnt + VW'(1);
            cm_od <= (bus.cnt_max_val != '0) && (cm_cnt == bus.cnt_max_val - VW'(1));
        end
    end
    assign bus.cnt_op_done = cm_od | force_od;

    typedef struct {
        bit is_done;
        int idx;
        bit err;
        int n_load;
        int n_inc;
        int maxv;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: which volumes start, how many increments, and the error flag.
    function automatic void push_layer(int nv, int mode, int k);
        exp_t e;
        int   nstart;
        int   md;
        md = mode;
        if (md == M_DESYNC && k == nv - 1) md = M_NORM;
        if (nv == 0) begin
            e = '{is_done: 1, idx: 0, err: 1, n_load: 0, n_inc: 0, maxv: 0};
            sb.push_back(e);
            return;
        end
        nstart = (md == M_NORM) ? nv : (md == M_EARLY) ? 0 : k + 1;
        for (int i = 0; i < nstart; i++) begin
            e = '{is_done: 0, idx: i, err: 0, n_load: 0, n_inc: 0, maxv: nv};
            sb.push_back(e);
        end
        e = '{is_done: 1, idx: 0, err: (md != M_NORM), n_load: 1,
              n_inc: (nstart > 0) ? nstart - 1 : 0, maxv: nv};
        sb.push_back(e);
    endfunction

    // Monitor: counts strobes and checks every vol_start / layer_done against the queue.
    initial begin : monitor
        exp_t e;
        int   m_load, m_inc, m_busy;
        bit   chk_idle;
        bit   last_err;
        m_load = 0; m_inc = 0; m_busy = 0; chk_idle = 0; last_err = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_load = 0; m_inc = 0; m_busy = 0; chk_idle = 0;
            end else begin
                if (chk_idle) begin
                    check("idle_after_done", int'(bus.layer_busy), 0);
                    check("err_held", int'(bus.layer_err), int'(last_err));
                    chk_idle = 0;
                end
                if (bus.cnt_load)   m_load++;
                if (bus.cnt_in_vol) m_inc++;
                if (bus.layer_busy) m_busy++;
                if (bus.vol_start) begin
                    if (sb.size() == 0) check("unexpected_vol_start", 1, 0);
                    else begin
                        e = sb.pop_front();
                        check("vs_kind", int'(e.is_done), 0);
                        check("vs_idx", int'(bus.vol_idx), e.idx);
                        check("vs_max", int'(bus.cnt_max_val), e.maxv);
                    end
                end
                if (bus.layer_done) begin
                    if (sb.size() == 0) check("unexpected_layer_done", 1, 0);
                    else begin
                        e = sb.pop_front();
                        check("ld_kind", int'(e.is_done), 1);
                        check("ld_err", int'(bus.layer_err), int'(e.err));
                        check("ld_clear", int'(bus.cnt_clear_vol), 1);
                        check("ld_loads", m_load, e.n_load);
                        check("ld_incs", m_inc, e.n_inc);
                        if (e.n_load == 0) check("zero_busy_cycles", m_busy, 1);
                        last_err = e.err;
                    end
                    m_load = 0; m_inc = 0; m_busy = 0; chk_idle = 1;
                end
            end
        end
    end

    task automatic wait_event(output int n, output bit vs, output bit ld);
        vs = 0; ld = 0; n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.vol_start || bus.layer_done) begin
                n  = i;
                vs = bus.vol_start;
                ld = bus.layer_done;
                break;
            end
        end
        if (!vs && !ld) check("event_timeout", 1, 0);
    endtask

    task automatic run_layer(int nv, int mode, int k);
        int n, idx, d, exp_lat;
        bit vs, ld, junk;
        push_layer(nv, mode, k);
        @(posedge clk); #1;
        bus.layer_start = 1'b1;
        bus.num_vol     = VW'(nv);
        @(posedge clk); #1;
        bus.layer_start = 1'b0;
        bus.num_vol     = VW'($urandom);
        if (mode == M_EARLY) bus.abort = 1'b1;
        exp_lat = (nv == 0) ? 1 : 2;
        wait_event(n, vs, ld);
        idx = 0;
        while (vs) begin
            check("lat_vol_start", n, 3);
            if (mode == M_DESYNC && idx == k) force_od = 1'b1;
            d    = $urandom_range(1, 5);
            junk = 1'($urandom_range(0, 1));
            for (int c = 0; c < d; c++) begin
                @(posedge clk); #1;
                bus.layer_start = junk;
                bus.num_vol     = VW'($urandom);
            end
            bus.layer_start = 1'b0;
            bus.vol_done    = 1'b1;
            if (mode == M_ABORT && idx == k) bus.abort = 1'b1;
            exp_lat = (mode == M_ABORT && idx == k) ? 1 : 2;
            @(posedge clk); #1;
            bus.vol_done = 1'b0;
            bus.abort    = 1'b0;
            idx++;
            wait_event(n, vs, ld);
        end
        if (ld) check("lat_layer_done", n, exp_lat);
        force_od  = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic reset_mid_wait();
        int n;
        bit vs, ld;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            e = '{is_done: 0, idx: i, err: 0, n_load: 0, n_inc: 0, maxv: 3};
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.layer_start = 1'b1;
        bus.num_vol     = VW'(3);
        @(posedge clk); #1;
        bus.layer_start = 1'b0;
        wait_event(n, vs, ld);
        @(posedge clk); #1;
        bus.vol_done = 1'b1;
        @(posedge clk); #1;
        bus.vol_done = 1'b0;
        wait_event(n, vs, ld);
        check("rst_pre_vs", int'(vs), 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_busy", int'(bus.layer_busy), 0);
        check("rst_done", int'(bus.layer_done), 0);
        check("rst_err", int'(bus.layer_err), 0);
        check("rst_vol_start", int'(bus.vol_start), 0);
        check("rst_vol_idx", int'(bus.vol_idx), 0);
        check("rst_load", int'(bus.cnt_load), 0);
        check("rst_inc", int'(bus.cnt_in_vol), 0);
        check("rst_clear", int'(bus.cnt_clear_vol), 0);
        check("rst_max", int'(bus.cnt_max_val), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin : driver
        int nv, mode, k;
        bus.layer_start = 1'b0;
        bus.num_vol     = '0;
        bus.abort       = 1'b0;
        bus.vol_done    = 1'b0;
        force_od        = 1'b0;
        rst_n           = 1'b0;
        @(negedge clk);
        check("init_busy", int'(bus.layer_busy), 0);
        check("init_done", int'(bus.layer_done), 0);
        check("init_err", int'(bus.layer_err), 0);
        check("init_vol_start", int'(bus.vol_start), 0);
        check("init_vol_idx", int'(bus.vol_idx), 0);
        check("init_max", int'(bus.cnt_max_val), 0);
        check("init_load", int'(bus.cnt_load), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_layer(3, M_NORM, 0);
        run_layer(1, M_NORM, 0);
        run_layer(0, M_NORM, 0);
        run_layer(5, M_ABORT, 1);
        run_layer(4, M_DESYNC, 1);
        run_layer(2, M_NORM, 0);
        run_layer(int'(MNV - 1), M_ABORT, 2);
        run_layer(6, M_EARLY, 0);
        reset_mid_wait();
        run_layer(2, M_NORM, 0);

        repeat (40) begin
            nv   = $urandom_range(0, 8);
            mode = $urandom_range(0, 3);
            k    = (nv > 0) ? $urandom_range(0, nv - 1) : 0;
            run_layer(nv, mode, k);
        end

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
